// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver.
// Holds the select/tag widths and the driver FSM state encoding.
package alu_pkg;

    localparam int ALU_SEL_W = 4;
    localparam int ALU_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } alu_drv_state_t;

endpackage

// File: rtl/alu_op_driver.sv
// Command-side front end for the registered N-bit ALU: accepts tagged ops,
// drives the ALU operands/select, waits out the ALU latency and returns the
// 2N-bit result with its tag on a valid/ready response port.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_op/cmd_a/cmd_b/cmd_tag
//   alu_operand1/2, alu_select  registered ALU inputs, stable between accepts
//   alu_result              ALU registered 2N-bit result
//   rsp_valid/rsp_ready     response handshake; rsp_result/rsp_tag
//   busy                    high whenever an op is in flight or unreturned
//   op_count                saturating count of completed responses
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_SEL_W-1:0] cmd_op,
    input  logic [N-1:0]         cmd_a,
    input  logic [N-1:0]         cmd_b,
    input  logic [ALU_TAG_W-1:0] cmd_tag,
    output logic [N-1:0]         alu_operand1,
    output logic [N-1:0]         alu_operand2,
    output logic [ALU_SEL_W-1:0] alu_select,
    input  logic [2*N-1:0]       alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*N-1:0]       rsp_result,
    output logic [ALU_TAG_W-1:0] rsp_tag,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    // LATENCY is at most 4, so three bits always hold the countdown.
    localparam int LAT_W = 3;

    alu_drv_state_t       state_q;
    logic [LAT_W-1:0]     cnt_q;
    logic [LAT_W-1:0]     cnt_d;
    logic [N-1:0]         op1_q;
    logic [N-1:0]         op2_q;
    logic [ALU_SEL_W-1:0] sel_q;
    logic [ALU_TAG_W-1:0] tag_q;
    logic [2*N-1:0]       res_q;
    logic [ALU_TAG_W-1:0] rtag_q;
    logic                 rsp_valid_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     op_count_q;
    logic [CNT_W-1:0]     op_count_d;
    logic                 accept;

    // A new command may slip in on the same edge the response retires.
    assign cmd_ready = (state_q == IDLE)
                     | ((state_q == RESP) & rsp_ready);
    assign accept    = cmd_valid & cmd_ready;

    assign cnt_d      = cnt_q - LAT_W'(1);
    assign op_count_d = (op_count_q == {CNT_W{1'b1}})
                      ? op_count_q
                      : op_count_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            sel_q       <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            rtag_q      <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_d;
                    end else begin
                        res_q       <= alu_result;
                        rtag_q      <= tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count_q  <= op_count_d;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Accept overrides the retire path above so a back-to-back
            // command goes straight to WAIT.
            if (accept) begin
                op1_q   <= cmd_a;
                op2_q   <= cmd_b;
                sel_q   <= cmd_op;
                tag_q   <= cmd_tag;
                cnt_q   <= LAT_W'(LATENCY);
                busy_q  <= 1'b1;
                state_q <= WAIT;
            end
        end
    end

    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign alu_select   = sel_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = res_q;
    assign rsp_tag      = rtag_q;
    assign busy         = busy_q;
    assign op_count     = op_count_q;

endmodule
